// File: rtl/button_param_ctrl_if.sv
// Pushbutton/switch inputs and DDS parameter outputs of the button control stage.
interface button_param_ctrl_if;
  localparam int unsigned FREQ_W = 16;
  localparam int unsigned AMP_W  = 8;

  logic              btnU_raw;
  logic              btnD_raw;
  logic              btnL_raw;
  logic              btnR_raw;
  logic              btnC_raw;
  logic [3:0]        sw;
  logic [FREQ_W-1:0] freq_word;
  logic [AMP_W-1:0]  amp_word;
  logic [1:0]        waveform_select;
  logic [1:0]        step_sel;
  logic              param_update;

  modport master (
    output btnU_raw, btnD_raw, btnL_raw, btnR_raw, btnC_raw, sw,
    input  freq_word, amp_word, waveform_select, step_sel, param_update
  );

  modport slave (
    input  btnU_raw, btnD_raw, btnL_raw, btnR_raw, btnC_raw, sw,
    output freq_word, amp_word, waveform_select, step_sel, param_update
  );
endinterface

// File: rtl/button_param_ctrl.sv
// Button/switch front end for the DDS: sync, debounce, auto-repeat and
// saturating step updates of the tuning word and amplitude.
module button_param_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter int unsigned FREQ_DEFAULT    = 1000,
  parameter int unsigned AMP_DEFAULT     = 255
) (
  input logic                clock,
  input logic                reset,
  button_param_ctrl_if.slave bus
);

  localparam int unsigned NBTN    = 5;
  localparam int unsigned FREQ_W  = 16;
  localparam int unsigned AMP_W   = 8;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam int unsigned BTN_U   = 0;
  localparam int unsigned BTN_D   = 1;
  localparam int unsigned BTN_L   = 2;
  localparam int unsigned BTN_R   = 3;
  localparam int unsigned BTN_C   = 4;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HELD,
    RPT_REPEAT
  } rpt_state_e;

  logic [NBTN-1:0]   btn_raw;
  logic [NBTN-1:0]   btn_meta;
  logic [NBTN-1:0]   btn_sync;
  logic [2:0]        sw_meta;
  logic [2:0]        sw_sync;
  logic              sw_unused_c;
  logic [NBTN-1:0]   db_level;
  logic [NBTN-1:0]   press_c;
  logic [1:0]        ud_evt_c;

  logic [FREQ_W-1:0] freq_q, freq_d, freq_step;
  logic [AMP_W-1:0]  amp_q, amp_d, amp_step;
  logic [FREQ_W:0]   freq_sum, freq_dif;
  logic [AMP_W:0]    amp_sum, amp_dif;
  logic [1:0]        wave_q;
  logic [1:0]        step_q, step_d;
  logic              update_q, update_d;
  logic              evt_u, evt_d, evt_l, evt_r, evt_c;

  assign btn_raw     = {bus.btnC_raw, bus.btnR_raw, bus.btnL_raw, bus.btnD_raw, bus.btnU_raw};
  assign sw_unused_c = bus.sw[3];

  // Two-flop synchronisers for buttons and switches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      sw_meta  <= bus.sw[2:0];
      sw_sync  <= sw_meta;
    end
  end

  // Per-button debounce; level flips after a run of disagreeing samples
  for (genvar b = 0; b < NBTN; b++) begin : g_db
    logic [DB_W-1:0] cnt_q;
    logic            level_q;
    logic            prev_q;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
        prev_q  <= 1'b0;
      end else begin
        prev_q <= level_q;
        if (btn_sync[b] == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
          cnt_q   <= '0;
          level_q <= ~level_q;
        end else begin
          cnt_q <= cnt_q + DB_W'(1);
        end
      end
    end

    assign db_level[b] = level_q;
    assign press_c[b]  = level_q & ~prev_q;
  end

  // Auto-repeat for Up (0) and Down (1)
  for (genvar g = 0; g < 2; g++) begin : g_rpt
    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] cnt_q, cnt_d;
    logic             evt;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state_q <= RPT_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      evt     = 1'b0;
      if (!db_level[g]) begin
        state_d = RPT_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          RPT_IDLE: begin
            if (press_c[g]) begin
              evt     = 1'b1;
              state_d = RPT_HELD;
              cnt_d   = '0;
            end
          end
          RPT_HELD: begin
            if (cnt_q == RPT_W'(HOLD_CYCLES - 1)) begin
              evt     = 1'b1;
              state_d = RPT_REPEAT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + RPT_W'(1);
            end
          end
          RPT_REPEAT: begin
            if (cnt_q == RPT_W'(REPEAT_CYCLES - 1)) begin
              evt   = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + RPT_W'(1);
            end
          end
          default: begin
            state_d = RPT_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    assign ud_evt_c[g] = evt;
  end

  assign evt_u = ud_evt_c[BTN_U];
  assign evt_d = ud_evt_c[BTN_D];
  assign evt_l = press_c[BTN_L];
  assign evt_r = press_c[BTN_R];
  assign evt_c = press_c[BTN_C];

  // Parameter update; Up/Down use the step in effect before any L/R this cycle
  always_comb begin
    freq_step = FREQ_W'(1) << {step_q, 2'b00};
    amp_step  = AMP_W'(1) << {step_q, 1'b0};
    freq_sum  = {1'b0, freq_q} + {1'b0, freq_step};
    freq_dif  = {1'b0, freq_q} - {1'b0, freq_step};
    amp_sum   = {1'b0, amp_q} + {1'b0, amp_step};
    amp_dif   = {1'b0, amp_q} - {1'b0, amp_step};
    freq_d    = freq_q;
    amp_d     = amp_q;
    step_d    = step_q;

    if (evt_c) begin
      freq_d = FREQ_W'(FREQ_DEFAULT);
      amp_d  = AMP_W'(AMP_DEFAULT);
    end else if (evt_u != evt_d) begin
      if (sw_sync[2]) begin
        if (evt_u) amp_d = amp_sum[AMP_W] ? '1 : amp_sum[AMP_W-1:0];
        else       amp_d = amp_dif[AMP_W] ? '0 : amp_dif[AMP_W-1:0];
      end else begin
        if (evt_u) freq_d = freq_sum[FREQ_W] ? '1 : freq_sum[FREQ_W-1:0];
        else       freq_d = (freq_dif[FREQ_W] || (freq_dif == '0)) ? FREQ_W'(1)
                                                                   : freq_dif[FREQ_W-1:0];
      end
    end

    if (evt_r && !evt_l && (step_q != 2'd3)) begin
      step_d = step_q + 2'd1;
    end else if (evt_l && !evt_r && (step_q != 2'd0)) begin
      step_d = step_q - 2'd1;
    end

    update_d = (freq_d != freq_q) || (amp_d != amp_q) || (sw_sync[1:0] != wave_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      freq_q   <= FREQ_W'(FREQ_DEFAULT);
      amp_q    <= AMP_W'(AMP_DEFAULT);
      wave_q   <= '0;
      step_q   <= '0;
      update_q <= 1'b0;
    end else begin
      freq_q   <= freq_d;
      amp_q    <= amp_d;
      wave_q   <= sw_sync[1:0];
      step_q   <= step_d;
      update_q <= update_d;
    end
  end

  assign bus.freq_word       = freq_q;
  assign bus.amp_word        = amp_q;
  assign bus.waveform_select = wave_q;
  assign bus.step_sel        = step_q;
  assign bus.param_update    = update_q;

endmodule
